// File: rtl/lcg_stim_pkg.sv
// Shared constants, types and helpers for the LCG stimulus generator.
// The LCG recurrence here must match the simulation stimulus generator bit for bit.
package lcg_stim_pkg;

  localparam logic [31:0] LCG_A = 32'h41C64E6D;
  localparam logic [31:0] LCG_C = 32'h00003039;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } stim_state_e;

  function automatic logic [31:0] lcg_next(input logic [31:0] x);
    return x * LCG_A + LCG_C;
  endfunction

  function automatic int nchunk(input int w);
    return (w + 31) / 32;
  endfunction

endpackage

// File: rtl/lcg_stim_gen_lcg_step.sv
// Combinational single LCG step (mod 2^32).
// One instance feeds both the fill path and the shadow prefetch path.
module lcg_step
  import lcg_stim_pkg::*;
(
  input  logic [31:0] i_x,
  output logic [31:0] o_x
);

  assign o_x = lcg_next(i_x);

endmodule

// File: rtl/lcg_stim_gen.sv
// Wide stimulus vector source driven by a 32-bit LCG, one LCG step per 32-bit chunk.
// Optional build macro LCG_STIM_PREFETCH_EN adds a shadow fill during PRESENT.
module lcg_stim_gen
  import lcg_stim_pkg::*;
#(
  parameter int          OUT_W        = 135,
  parameter int          CNT_W        = 16,
  parameter logic [31:0] SEED_DEFAULT = 32'h415C1FB4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [31:0]      seed_i,
  input  logic [CNT_W-1:0] num_vec_i,
  output logic [OUT_W-1:0] data_o,
  output logic             vld_o,
  input  logic             rdy_i,
  output logic [CNT_W-1:0] vec_idx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int NCH  = nchunk(OUT_W);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

  stim_state_e      r_state;
  stim_state_e      w_state_next;
  logic [31:0]      r_lcg;
  logic [31:0]      w_lcg_next;
  logic [OUT_W-1:0] r_fill;
  logic [OUT_W-1:0] w_fill_merged;
  logic [OUT_W-1:0] r_data;
  logic [CH_W-1:0]  r_cnt;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_vec_idx;
  logic             r_vld;
  logic             r_done;
  logic             r_full;
  logic             w_hs;
  logic             w_accept;
  logic             w_step;
  logic             w_pf_step;
  logic             w_last_chunk;
  logic             w_last_vec;

  lcg_step u_step (
    .i_x (r_lcg),
    .o_x (w_lcg_next)
  );

  // Fill buffer with the chunk being written this cycle already merged in;
  // the last chunk only keeps the low bits that fit in OUT_W.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
      localparam int LO = gi * 32;
      localparam int HI = ((gi + 1) * 32 > OUT_W) ? (OUT_W - 1) : (gi * 32 + 31);
      assign w_fill_merged[HI:LO] = (r_cnt == CH_W'(gi)) ? w_lcg_next[HI-LO:0] : r_fill[HI:LO];
    end
  endgenerate

`ifdef LCG_STIM_PREFETCH_EN
  // Shadow fill runs only while a further vector is still owed to this run.
  assign w_pf_step = (r_state == PRESENT) && !r_full && (r_remaining > CNT_W'(1));
`else
  assign w_pf_step = 1'b0;
`endif

  assign w_hs         = r_vld & rdy_i;
  assign w_step       = (r_state == FILL) || w_pf_step;
  assign w_last_chunk = w_step && (r_cnt == LAST_CH);
  assign w_last_vec   = (r_remaining == CNT_W'(1));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start_i) begin
          w_accept     = 1'b1;
          w_state_next = (num_vec_i == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (w_last_chunk) w_state_next = PRESENT;
      end
      PRESENT: begin
        if (w_hs) begin
          if (w_last_vec) begin
            w_state_next = DONE;
          end else if (!(r_full || w_last_chunk)) begin
            w_state_next = FILL;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lcg       <= SEED_DEFAULT;
      r_fill      <= '0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_remaining <= '0;
      r_vec_idx   <= '0;
      r_vld       <= 1'b0;
      r_done      <= 1'b0;
      r_full      <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_step) begin
        r_lcg  <= w_lcg_next;
        r_fill <= w_fill_merged;
        r_cnt  <= w_last_chunk ? '0 : r_cnt + 1'b1;
      end

      if (w_accept) begin
        r_lcg       <= seed_i;
        r_remaining <= num_vec_i;
        r_vec_idx   <= '0;
        r_cnt       <= '0;
        r_full      <= 1'b0;
        r_vld       <= 1'b0;
        r_done      <= (num_vec_i == '0);
      end

      if ((r_state == FILL) && w_last_chunk) begin
        r_data <= w_fill_merged;
        r_vld  <= 1'b1;
      end

      if (r_state == PRESENT) begin
        if (w_last_chunk && !w_hs) r_full <= 1'b1;
        if (w_hs) begin
          r_remaining <= r_remaining - 1'b1;
          r_vec_idx   <= r_vec_idx + 1'b1;
          r_full      <= 1'b0;
          if (w_last_vec) begin
            r_vld  <= 1'b0;
            r_done <= 1'b1;
          end else if (r_full) begin
            r_data <= r_fill;
          end else if (w_last_chunk) begin
            r_data <= w_fill_merged;
          end else begin
            r_vld <= 1'b0;
          end
        end
      end
    end
  end

  assign data_o    = r_data;
  assign vld_o     = r_vld;
  assign vec_idx_o = r_vec_idx;
  assign busy_o    = (r_state == FILL) || (r_state == PRESENT);
  assign done_o    = r_done;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Directed bench for lcg_stim_gen: reset, single vector, long run, backpressure,
// zero-length run with ignored start, and reset mid-fill with restart.
module tb_lcg_stim_gen;

  localparam int OUT_W = 135;
  localparam int CNT_W = 16;
`ifdef LCG_STIM_PREFETCH_EN
  localparam int PERIOD = 5;
`else
  localparam int PERIOD = 6;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic [31:0]      seed_i = '0;
  logic [CNT_W-1:0] num_vec_i = '0;
  logic             rdy_i = 1'b0;
  logic [OUT_W-1:0] data_o;
  logic             vld_o;
  logic [CNT_W-1:0] vec_idx_o;
  logic             busy_o;
  logic             done_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  lcg_stim_gen #(
    .OUT_W        (OUT_W),
    .CNT_W        (CNT_W),
    .SEED_DEFAULT (32'h415C1FB4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .seed_i    (seed_i),
    .num_vec_i (num_vec_i),
    .data_o    (data_o),
    .vld_o     (vld_o),
    .rdy_i     (rdy_i),
    .vec_idx_o (vec_idx_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sw_lcg(input logic [31:0] x);
    return x * 32'h41C64E6D + 32'h00003039;
  endfunction

  task automatic model_vec(inout logic [31:0] s, output logic [OUT_W-1:0] v);
    logic [159:0] t;
    t = '0;
    for (int k = 0; k < 5; k++) begin
      s = sw_lcg(s);
      t[k*32 +: 32] = s;
    end
    v = t[OUT_W-1:0];
  endtask

  task automatic start_run(input logic [31:0] seed, input logic [CNT_W-1:0] n);
    @(negedge clk);
    seed_i    = seed;
    num_vec_i = n;
    start_i   = 1'b1;
    @(negedge clk);
    start_i   = 1'b0;
  endtask

  task automatic wait_vld(input int max, output int cycles);
    cycles = 0;
    while (!vld_o && cycles < max) begin
      @(negedge clk);
      cycles++;
    end
    chk("vld_wait", 160'(vld_o), 160'(1));
  endtask

  task automatic check_vec(input string tag, inout logic [31:0] s, input int idx);
    logic [OUT_W-1:0] e;
    model_vec(s, e);
    chk({tag, "_data"}, 160'(data_o), 160'(e));
    chk({tag, "_idx"}, 160'(vec_idx_o), 160'(idx));
    $display("%s vec %0d idx %0d data %h", tag, idx, vec_idx_o, data_o);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]      s;
    logic [OUT_W-1:0] e;
    int               c;
    int               last;

    // 1: reset, then idle with no start
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t1_vld", 160'(vld_o), 160'(0));
      chk("t1_busy", 160'(busy_o), 160'(0));
      chk("t1_done", 160'(done_o), 160'(0));
      chk("t1_data", 160'(data_o), 160'(0));
    end

    // 2: single vector from seed 1, latency and done timing
    rdy_i = 1'b1;
    start_run(32'd1, 16'd1);
    chk("t2_busy", 160'(busy_o), 160'(1));
    wait_vld(20, c);
    chk("t2_latency", 160'(c + 1), 160'(6));
    chk("t2_chunk0", 160'(data_o[31:0]), 160'(32'h41C67EA6));
    s = 32'd1;
    check_vec("t2", s, 0);
    @(negedge clk);
    chk("t2_done", 160'(done_o), 160'(1));
    chk("t2_vld_low", 160'(vld_o), 160'(0));
    chk("t2_busy_low", 160'(busy_o), 160'(0));

    // 3: default seed, 200 vectors, continuous ready
    start_run(32'h415C1FB4, 16'd200);
    s = 32'h415C1FB4;
    last = 0;
    for (int v = 0; v < 200; v++) begin
      wait_vld(20, c);
      check_vec("t3", s, v);
      if (v > 0) chk("t3_period", 160'(cyc - last), 160'(PERIOD));
      last = cyc;
      @(negedge clk);
    end
    chk("t3_done", 160'(done_o), 160'(1));
    chk("t3_vld_low", 160'(vld_o), 160'(0));

    // 4: backpressure holds the vector stable
    rdy_i = 1'b0;
    start_run(32'h12345678, 16'd3);
    s = 32'h12345678;
    wait_vld(20, c);
    model_vec(s, e);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_data", 160'(data_o), 160'(e));
      chk("t4_hold_idx", 160'(vec_idx_o), 160'(0));
      chk("t4_hold_vld", 160'(vld_o), 160'(1));
      @(negedge clk);
    end
    $display("t4 vec 0 idx %0d data %h", vec_idx_o, data_o);
    rdy_i = 1'b1;
    @(negedge clk);
    for (int v = 1; v < 3; v++) begin
      wait_vld(20, c);
      check_vec("t4", s, v);
      @(negedge clk);
    end
    chk("t4_done", 160'(done_o), 160'(1));

    // 5: zero-length run, then a start pulse during FILL is ignored
    start_run(32'd5, 16'd0);
    chk("t5_done", 160'(done_o), 160'(1));
    chk("t5_busy", 160'(busy_o), 160'(0));
    for (int i = 0; i < 8; i++) begin
      chk("t5_no_vld", 160'(vld_o), 160'(0));
      @(negedge clk);
    end
    rdy_i = 1'b0;
    start_run(32'd7, 16'd2);
    chk("t5_busy_fill", 160'(busy_o), 160'(1));
    chk("t5_done_clr", 160'(done_o), 160'(0));
    seed_i    = 32'd99;
    num_vec_i = 16'd5;
    start_i   = 1'b1;
    @(negedge clk);
    start_i   = 1'b0;
    rdy_i     = 1'b1;
    s = 32'd7;
    for (int v = 0; v < 2; v++) begin
      wait_vld(20, c);
      check_vec("t5", s, v);
      @(negedge clk);
    end
    chk("t5_done_end", 160'(done_o), 160'(1));

    // 6: reset during FILL, then restart with the same seed
    start_run(32'hCAFEBABE, 16'd4);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", 160'(vld_o), 160'(0));
    chk("t6_rst_busy", 160'(busy_o), 160'(0));
    chk("t6_rst_done", 160'(done_o), 160'(0));
    chk("t6_rst_data", 160'(data_o), 160'(0));
    chk("t6_rst_idx", 160'(vec_idx_o), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    start_run(32'hCAFEBABE, 16'd4);
    s = 32'hCAFEBABE;
    wait_vld(20, c);
    chk("t6_latency", 160'(c + 1), 160'(6));
    last = cyc;
    check_vec("t6", s, 0);
    @(negedge clk);
    for (int v = 1; v < 4; v++) begin
      wait_vld(20, c);
      chk("t6_period", 160'(cyc - last), 160'(PERIOD));
      last = cyc;
      check_vec("t6", s, v);
      @(negedge clk);
    end
    chk("t6_done", 160'(done_o), 160'(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
